// File: rtl/fir_serial_mac_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the serial-MAC FIR filter and its helpers:
//   - clog2()         : ceiling log2, usable in parameter expressions
//   - fir_state_t     : controller states (IDLE, MAC, OUT)
//   - DEFAULT_COEFS   : power-up low-pass coefficient set (8 taps)
//   - default_coef()  : default coefficient for any tap index (zero-filled)
//   - acc_width()     : accumulator width that can never overflow
// ---------------------------------------------------------------------------
package fir_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  localparam int DEFAULT_COEF_COUNT = 8;
  localparam int DEFAULT_COEFS [DEFAULT_COEF_COUNT] =
    '{1638, 3277, 4915, 6553, 6553, 4915, 3277, 1638};

  // Filters with more taps than the default set get zeros in the extra taps;
  // filters with fewer taps simply never ask for the tail of the set.
  function automatic int default_coef(input int index);
    if (index < DEFAULT_COEF_COUNT) begin
      return DEFAULT_COEFS[index];
    end
    return 0;
  endfunction

  // Full-precision product plus clog2(taps) guard bits: the sum of all taps
  // always fits, so the accumulator needs no overflow handling.
  function automatic int acc_width(input int data_width, input int coeff_width,
                                   input int taps);
    return data_width + coeff_width + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// ---------------------------------------------------------------------------
// fir_serial_mac_if
// Bundles the sample input handshake, result output handshake and the
// coefficient write port of the serial-MAC FIR.
//   in_sample/in_valid/in_ready       : sample stream into the filter
//   out_sample/out_sat/out_valid/out_ready : filtered result stream
//   coef_we/coef_addr/coef_wdata/coef_busy : runtime coefficient writes
// Modports:
//   slave  : the filter side
//   master : the source/sink/controller side
// ---------------------------------------------------------------------------
interface fir_serial_mac_if #(
  parameter int TAPS        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int OUT_WIDTH   = 16
);
  import fir_pkg::*;

  localparam int ADDR_WIDTH = clog2(TAPS);

  logic signed [DATA_WIDTH-1:0]  in_sample;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [OUT_WIDTH-1:0]   out_sample;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_sat;
  logic                          coef_we;
  logic [ADDR_WIDTH-1:0]         coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_wdata;
  logic                          coef_busy;

  modport slave (
    input  in_sample, in_valid, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_sample, out_valid, out_sat, coef_busy
  );

  modport master (
    output in_sample, in_valid, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_sample, out_valid, out_sat, coef_busy
  );

endinterface

// File: rtl/fir_round_sat.sv
// ---------------------------------------------------------------------------
// fir_round_sat
// Combinational rescaling of a wide signed accumulator to the output width:
// arithmetic right shift by SHIFT with round-half-up, then clip to the signed
// OUT_WIDTH range.
//   i_acc    : signed accumulator value (ACC_WIDTH bits)
//   o_sample : rounded and saturated result (OUT_WIDTH bits)
//   o_sat    : 1 when the result had to be clipped
// ---------------------------------------------------------------------------
module fir_round_sat #(
  parameter int ACC_WIDTH = 35,
  parameter int SHIFT     = 15,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [OUT_WIDTH-1:0] o_sample,
  output logic                        o_sat
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int SUM_W = ACC_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] MAX_V =
    {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V =
    {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shifted;

  // Adding half an LSB before the floor-shift gives round-half-up; with no
  // shift there is nothing to round.
  if (SHIFT > 0) begin : g_round
    assign w_sum = {i_acc[ACC_WIDTH-1], i_acc} + (SUM_W'(1) << (SHIFT - 1));
  end else begin : g_no_round
    assign w_sum = {i_acc[ACC_WIDTH-1], i_acc};
  end

  assign w_shifted = w_sum >>> SHIFT;

  // Clip to the representable output range and flag when that happened.
  always_comb begin
    o_sample = w_shifted[OUT_WIDTH-1:0];
    o_sat    = 1'b0;
    if (w_shifted > MAX_V) begin
      o_sample = MAX_V[OUT_WIDTH-1:0];
      o_sat    = 1'b1;
    end else if (w_shifted < MIN_V) begin
      o_sample = MIN_V[OUT_WIDTH-1:0];
      o_sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// ---------------------------------------------------------------------------
// fir_serial_mac
// Time-multiplexed FIR filter: one signed multiplier and one accumulator are
// shared across TAPS cycles per sample. Coefficients are runtime-writable
// while the filter is idle. Results are rounded and saturated.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fir_serial_mac_if.slave (sample in, result out, coefficient port)
// One sample is processed at a time: IDLE accepts, MAC runs TAPS cycles,
// OUT holds the result until the downstream handshake.
// ---------------------------------------------------------------------------
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int TAPS        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = COEFF_WIDTH - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_serial_mac_if.slave bus
);

  localparam int ADDR_WIDTH = clog2(TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, TAPS);

  fir_state_t r_state;
  fir_state_t w_next_state;

  logic signed [DATA_WIDTH-1:0]  r_taps  [TAPS];
  logic signed [COEFF_WIDTH-1:0] r_coefs [TAPS];
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [ADDR_WIDTH-1:0]         r_idx;
  logic signed [OUT_WIDTH-1:0]   r_out_sample;
  logic                          r_out_sat;

  logic signed [PROD_WIDTH-1:0]  w_product;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;
  logic signed [OUT_WIDTH-1:0]   w_rs_sample;
  logic                          w_rs_sat;
  logic                          w_last;
  logic                          w_addr_ok;
  logic                          w_in_ready;
  logic                          w_coef_busy;
  logic                          w_out_valid;

  assign w_product  = r_taps[r_idx] * r_coefs[r_idx];
  assign w_acc_next = r_acc + {{(ACC_WIDTH-PROD_WIDTH){w_product[PROD_WIDTH-1]}}, w_product};
  assign w_last     = (r_idx == ADDR_WIDTH'(TAPS - 1));
  assign w_addr_ok  = ({{(32-ADDR_WIDTH){1'b0}}, bus.coef_addr} < 32'(TAPS));

  // The result is rescaled from the accumulator value that includes the final
  // term, so it can be registered in the same cycle as the last MAC step.
  fir_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .i_acc    (w_acc_next),
    .o_sample (w_rs_sample),
    .o_sat    (w_rs_sat)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and handshake outputs; everything outside IDLE blocks
  // both new samples and coefficient writes.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_coef_busy  = 1'b1;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready  = 1'b1;
        w_coef_busy = 1'b0;
        if (bus.in_valid) begin
          w_next_state = ST_MAC;
        end
      end
      ST_MAC: begin
        if (w_last) begin
          w_next_state = ST_OUT;
        end
      end
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: delay line and coefficient updates in IDLE (a write landing in
  // the same cycle as a sample is already visible to that sample's MAC),
  // one multiply-accumulate per cycle in MAC, result capture on the last term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        r_taps[k]  <= '0;
        r_coefs[k] <= COEFF_WIDTH'(default_coef(k));
      end
      r_acc        <= '0;
      r_idx        <= '0;
      r_out_sample <= '0;
      r_out_sat    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.coef_we && w_addr_ok) begin
            r_coefs[bus.coef_addr] <= bus.coef_wdata;
          end
          if (bus.in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              r_taps[k] <= r_taps[k-1];
            end
            r_taps[0] <= bus.in_sample;
            r_acc     <= '0;
            r_idx     <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + ADDR_WIDTH'(1);
          if (w_last) begin
            r_out_sample <= w_rs_sample;
            r_out_sat    <= w_rs_sat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.coef_busy  = w_coef_busy;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sample = r_out_sample;
  assign bus.out_sat    = r_out_sat;

endmodule

// File: tb/tb_fir_serial_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_serial_mac
// Self-checking bench for fir_serial_mac. A behavioural model keeps the
// accepted-sample history and the coefficient set as plain integer arrays and
// computes each expected output as a dot product, rounded half up and
// clipped. Scenario tasks run in sequence from one initial block.
// ---------------------------------------------------------------------------
module tb_fir_serial_mac;
  import fir_pkg::*;

  localparam int TAPS  = 8;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int OW    = 16;
  localparam int SHIFT = CW - 1;
  localparam int AW    = clog2(TAPS);

  localparam int IMPULSE_RESP [8] = '{1638, 3277, 4915, 6553, 6553, 4915, 3277, 1638};

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  longint m_hist [TAPS];
  longint m_coef [TAPS];

  fir_serial_mac_if #(
    .TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .OUT_WIDTH(OW)
  ) bus ();

  fir_serial_mac #(
    .TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .OUT_WIDTH(OW), .SHIFT(SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: reset restores the default low-pass set and an empty history.
  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_hist[k] = 0;
      m_coef[k] = IMPULSE_RESP[k];
    end
  endfunction

  function automatic void model_push(input longint s);
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
  endfunction

  function automatic void model_result(output logic signed [OW-1:0] r, output logic sat);
    longint acc;
    longint q;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -(longint'(1) <<< (OW - 1));
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += m_hist[k] * m_coef[k];
    q = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (q > maxv) begin
      q = maxv;
      sat = 1'b1;
    end else if (q < minv) begin
      q = minv;
      sat = 1'b1;
    end
    r = OW'(q);
  endfunction

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Writes one coefficient while the filter is idle.
  task automatic write_coef(input int addr, input logic signed [CW-1:0] val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = val;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    m_coef[addr] = longint'(val);
  endtask

  // Sends one sample and collects its result.
  // cw_mode: 0 none, 1 coefficient write together with the sample,
  //          2 coefficient write one cycle into the MAC phase (must be dropped).
  // lat is the number of edges from acceptance to the first edge at which
  // out_valid is seen high; -1 on timeout.
  task automatic run_sample(input logic signed [DW-1:0] s, input int stall,
                            input int cw_mode, input int cw_addr,
                            input logic signed [CW-1:0] cw_data,
                            output logic signed [OW-1:0] got, output logic got_sat,
                            output logic signed [OW-1:0] exp_s, output logic exp_sat,
                            output int lat);
    int waited;
    bus.out_ready = (stall == 0);
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    if (cw_mode == 1) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(cw_addr);
      bus.coef_wdata = cw_data;
    end
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    if (cw_mode == 1 && cw_addr < TAPS) m_coef[cw_addr] = longint'(cw_data);
    model_push(longint'(s));
    model_result(exp_s, exp_sat);
    lat = 1;
    if (cw_mode == 2) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(cw_addr);
      bus.coef_wdata = cw_data;
      @(posedge clk);
      #1;
      bus.coef_we = 1'b0;
      lat = 2;
    end
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      lat = -1;
      got = 'x;
      got_sat = 1'bx;
      bus.out_ready = 1'b1;
      return;
    end
    got = bus.out_sample;
    got_sat = bus.out_sat;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_sample !== 16'sd0) begin
      n_errors++;
      $display("[TB] FAIL reset_out_sample: got %0d expected 0", bus.out_sample);
    end
    n_checks++;
    if (bus.out_sat !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_out_sat: got %b expected 0", bus.out_sat);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_checks++;
    if (bus.coef_busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_coef_busy: got %b expected 0", bus.coef_busy);
    end
  endtask

  task automatic test_impulse();
    logic signed [OW-1:0] got, exs;
    logic gs, es;
    int lat;
    for (int i = 0; i < TAPS; i++) begin
      run_sample((i == 0) ? 16'sd32767 : 16'sd0, 0, 0, 0, '0, got, gs, exs, es, lat);
      n_checks++;
      if (got !== OW'(IMPULSE_RESP[i])) begin
        n_errors++;
        $display("[TB] FAIL impulse_value[%0d]: got %0d expected %0d", i, got, IMPULSE_RESP[i]);
      end
      n_checks++;
      if (gs !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL impulse_sat[%0d]: got %b expected 0", i, gs);
      end
      n_checks++;
      if (lat != TAPS + 1) begin
        n_errors++;
        $display("[TB] FAIL impulse_latency[%0d]: got %0d expected %0d", i, lat, TAPS + 1);
      end
    end
  endtask

  task automatic test_dc_step();
    logic signed [OW-1:0] got, exs;
    logic gs, es;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_sample(16'sd32767, 0, 0, 0, '0, got, gs, exs, es, lat);
      if (i < TAPS - 1) begin
        n_checks++;
        if (got !== exs || gs !== es) begin
          n_errors++;
          $display("[TB] FAIL dc_ramp[%0d]: got %0d sat %b expected %0d sat %b", i, got, gs, exs, es);
        end
      end else begin
        n_checks++;
        if (got !== 16'sd32765 || gs !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL dc_steady[%0d]: got %0d sat %b expected 32765 sat 0", i, got, gs);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [OW-1:0] got, exs;
    logic gs, es;
    int lat;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd32767);
    for (int i = 0; i < TAPS; i++) begin
      run_sample(16'sd32767, 0, 0, 0, '0, got, gs, exs, es, lat);
      n_checks++;
      if (i == TAPS - 1) begin
        if (got !== 16'h7FFF || gs !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL sat_pos: got %0d sat %b expected 32767 sat 1", got, gs);
        end
      end else if (got !== exs || gs !== es) begin
        n_errors++;
        $display("[TB] FAIL sat_pos_ramp[%0d]: got %0d sat %b expected %0d sat %b", i, got, gs, exs, es);
      end
    end
    for (int i = 0; i < TAPS; i++) begin
      run_sample(16'sh8000, 0, 0, 0, '0, got, gs, exs, es, lat);
      n_checks++;
      if (i == TAPS - 1) begin
        if (got !== 16'h8000 || gs !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL sat_neg: got %0d sat %b expected -32768 sat 1", got, gs);
        end
      end else if (got !== exs || gs !== es) begin
        n_errors++;
        $display("[TB] FAIL sat_neg_ramp[%0d]: got %0d sat %b expected %0d sat %b", i, got, gs, exs, es);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [OW-1:0] held, exs;
    logic es;
    int waited;
    apply_reset(2);
    bus.out_ready = 1'b0;
    bus.in_sample = 16'sd20000;
    bus.in_valid  = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_push(20000);
    model_result(exs, es);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    held = bus.out_sample;
    n_checks++;
    if (held !== exs || bus.out_sat !== es) begin
      n_errors++;
      $display("[TB] FAIL bp_first: got %0d sat %b expected %0d sat %b", held, bus.out_sat, exs, es);
    end
    // A second sample is presented and held by the source during the stall.
    bus.in_sample = -16'sd12000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sample !== exs) begin
        n_errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid %b sample %0d expected valid 1 sample %0d",
                 i, bus.out_valid, bus.out_sample, exs);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL bp_release: got in_ready %b out_valid %b expected 1 and 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_push(-12000);
    model_result(exs, es);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sample !== exs || bus.out_sat !== es) begin
      n_errors++;
      $display("[TB] FAIL bp_second: got valid %b sample %0d sat %b expected valid 1 sample %0d sat %b",
               bus.out_valid, bus.out_sample, bus.out_sat, exs, es);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_coef_write_rules();
    logic signed [OW-1:0] got, exs;
    logic gs, es;
    int lat;
    apply_reset(2);
    // Write during MAC must be dropped: response stays the default one.
    for (int i = 0; i < TAPS; i++) begin
      run_sample((i == 0) ? 16'sd32767 : 16'sd0, 0, (i == 0) ? 2 : 0, 0, 16'sd100,
                 got, gs, exs, es, lat);
      n_checks++;
      if (got !== OW'(IMPULSE_RESP[i]) || gs !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL coef_busy_drop[%0d]: got %0d sat %b expected %0d sat 0",
                 i, got, gs, IMPULSE_RESP[i]);
      end
    end
    // Write while idle takes effect on the next sample.
    write_coef(0, 16'sd100);
    for (int i = 0; i < TAPS; i++) begin
      run_sample((i == 0) ? 16'sd32767 : 16'sd0, 0, 0, 0, '0, got, gs, exs, es, lat);
      n_checks++;
      if (i == 0) begin
        if (got !== 16'sd100 || gs !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL coef_idle_write: got %0d sat %b expected 100 sat 0", got, gs);
        end
      end else if (got !== exs || gs !== es) begin
        n_errors++;
        $display("[TB] FAIL coef_idle_tail[%0d]: got %0d sat %b expected %0d sat %b", i, got, gs, exs, es);
      end
    end
    // Write in the same cycle as the sample is used by that sample.
    run_sample(16'sd32767, 0, 1, 0, 16'sd300, got, gs, exs, es, lat);
    n_checks++;
    if (got !== 16'sd300 || gs !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL coef_same_cycle: got %0d sat %b expected 300 sat 0", got, gs);
    end
  endtask

  task automatic test_reset_in_mac();
    logic signed [OW-1:0] got, exs;
    logic gs, es;
    int lat;
    int waited;
    int valid_seen;
    bus.out_ready = 1'b1;
    bus.in_sample = 16'sd12345;
    bus.in_valid  = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    valid_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid !== 1'b0) valid_seen++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (valid_seen != 0) begin
      n_errors++;
      $display("[TB] FAIL rst_mac_no_output: got %0d valid cycles expected 0", valid_seen);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.coef_busy !== 1'b0 || bus.out_sample !== 16'sd0) begin
      n_errors++;
      $display("[TB] FAIL rst_mac_state: got in_ready %b coef_busy %b out_sample %0d expected 1 0 0",
               bus.in_ready, bus.coef_busy, bus.out_sample);
    end
    for (int i = 0; i < TAPS; i++) begin
      run_sample((i == 0) ? 16'sd32767 : 16'sd0, 0, 0, 0, '0, got, gs, exs, es, lat);
      n_checks++;
      if (got !== OW'(IMPULSE_RESP[i]) || gs !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL rst_mac_impulse[%0d]: got %0d sat %b expected %0d sat 0",
                 i, got, gs, IMPULSE_RESP[i]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [OW-1:0] got, exs;
    logic gs, es;
    int lat;
    int mode;
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'($urandom));
    for (int i = 0; i < 30; i++) begin
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_sample(DW'($urandom), $urandom_range(0, 2), mode, $urandom_range(0, TAPS - 1),
                 CW'($urandom), got, gs, exs, es, lat);
      n_checks++;
      if (got !== exs || gs !== es) begin
        n_errors++;
        $display("[TB] FAIL random[%0d]: got %0d sat %b expected %0d sat %b", i, got, gs, exs, es);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_sample  = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    test_reset();
    test_impulse();
    test_dc_step();
    test_saturation();
    test_backpressure();
    test_coef_write_rules();
    test_reset_in_mac();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
